// File: rtl/slave_tx_pkg.sv
`default_nettype none
// ============================================================
// Package : slave_tx_pkg
// Desc    : FSM state encoding shared by the serializer blocks.
// Rev     : 1.0
// ============================================================
package slave_tx_pkg;

    localparam int c_STATE_W = 2;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_DATA   = 2'd1;
    localparam state_t c_ST_PARITY = 2'd2;

endpackage
`default_nettype wire

// File: rtl/slave_tx_fifo.sv
`default_nettype none
// ============================================================
// Module : slave_tx_fifo
// Desc   : Synchronous word FIFO, registered level, no fall-through.
// Rev    : 1.0
// ============================================================
module slave_tx_fifo
    import slave_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic [DATA_WIDTH-1:0]              pop_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH+1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_LVL_W'(1);
                2'b01:   r_count <= r_count - c_LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign level    = r_count;

endmodule
`default_nettype wire

// File: rtl/slave_tx_serializer.sv
`default_nettype none
// ============================================================
// Module : slave_tx_serializer
// Desc   : Buffers slave words and shifts them out as serial frames.
//          Define SLAVE_TX_PARITY_EN to append an even-parity bit.
// Rev    : 1.0
// ============================================================
module slave_tx_serializer
    import slave_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              datain,
    input  logic                               slave_valid,
    output logic                               slave_ready,
    input  logic                               master_ready,
    output logic                               tx_data,
    output logic                               tx_valid,
    output logic                               slave_tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int c_LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH-1);
`ifndef SLAVE_TX_PARITY_EN
    localparam logic [c_CNT_W-1:0] c_DONE_CNT = c_CNT_W'(DATA_WIDTH-2);
`endif

    function automatic logic f_first(input logic [DATA_WIDTH-1:0] word);
        return (MSB_FIRST != 0) ? word[DATA_WIDTH-1] : word[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_shift(input logic [DATA_WIDTH-1:0] word);
        return (MSB_FIRST != 0) ? (word << 1) : (word >> 1);
    endfunction

    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    state_t                r_state,    w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
    logic [c_CNT_W-1:0]    r_cnt,      w_cnt_nxt;
    logic                  r_tx_data,  w_tx_data_nxt;
    logic                  r_tx_valid, w_tx_valid_nxt;
    logic                  r_done,     w_done_nxt;

    assign slave_ready = (fifo_level < c_LVL_W'(FIFO_DEPTH));
    assign w_push      = slave_valid & slave_ready;

    slave_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (datain),
        .pop       (w_pop),
        .pop_data  (w_head),
        .level     (fifo_level)
    );

`ifdef SLAVE_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // Output registers hold the bit on the wire; r_shift holds the bits still to send.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_tx_data_nxt  = 1'b0;
        w_tx_valid_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if ((fifo_level != '0) && master_ready) begin
                    w_pop          = 1'b1;
                    w_shift_nxt    = f_shift(w_head);
                    w_cnt_nxt      = '0;
                    w_tx_data_nxt  = f_first(w_head);
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (r_cnt == c_LAST) begin
`ifdef SLAVE_TX_PARITY_EN
                    w_tx_data_nxt  = r_parity;
                    w_tx_valid_nxt = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = c_ST_PARITY;
`else
                    w_state_nxt    = c_ST_IDLE;
`endif
                end else begin
                    w_cnt_nxt      = r_cnt + c_CNT_W'(1);
                    w_shift_nxt    = f_shift(r_shift);
                    w_tx_data_nxt  = f_first(r_shift);
                    w_tx_valid_nxt = 1'b1;
`ifndef SLAVE_TX_PARITY_EN
                    w_done_nxt     = (r_cnt == c_DONE_CNT);
`endif
                end
            end
`ifdef SLAVE_TX_PARITY_EN
            c_ST_PARITY: begin
                w_state_nxt = c_ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tx_data  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign slave_tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_slave_tx_serializer.sv
`default_nettype none
// ============================================================
// Module : tb_slave_tx_serializer
// Desc   : Self-checking bench: vector table, scoreboard, corner sequences.
// Rev    : 1.0
// ============================================================
module tb_slave_tx_serializer;

`ifdef SLAVE_TX_PARITY_EN
    localparam int c_FRAME = 9;
`else
    localparam int c_FRAME = 8;
`endif

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] seq;   // bit order on the wire, first bit in seq[7]
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] datain;
    logic       slave_valid;
    logic       slave_ready;
    logic       master_ready;
    logic       tx_data;
    logic       tx_valid;
    logic       slave_tx_done;
    logic [2:0] fifo_level;

    logic [7:0] m_datain;
    logic       m_valid;
    logic       m_ready;
    logic       m_mready;
    logic       m_tx_data;
    logic       m_tx_valid;
    logic       m_done;
    logic [2:0] m_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb_q[$];
    int         gap_q[$];
    int         mon_cnt = 0;
    logic [7:0] mon_acc;
    logic [7:0] exp_w;
    int         cyc = 0;
    int         last_done_cyc = 0;
    int         frames_seen = 0;

    always #5 clk = ~clk;

    slave_tx_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .datain        (datain),
        .slave_valid   (slave_valid),
        .slave_ready   (slave_ready),
        .master_ready  (master_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .slave_tx_done (slave_tx_done),
        .fifo_level    (fifo_level)
    );

    slave_tx_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut_msb (
        .clk           (clk),
        .reset         (reset),
        .datain        (m_datain),
        .slave_valid   (m_valid),
        .slave_ready   (m_ready),
        .master_ready  (m_mready),
        .tx_data       (m_tx_data),
        .tx_valid      (m_tx_valid),
        .slave_tx_done (m_done),
        .fifo_level    (m_level)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the LSB-first instance: rebuilds each frame and compares.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mon_cnt = 0;
        end else if (tx_valid) begin
            if (mon_cnt == 0) gap_q.push_back(cyc - last_done_cyc - 1);
            if (mon_cnt < 8) mon_acc[mon_cnt[2:0]] = tx_data;
            mon_cnt++;
            if (slave_tx_done) begin
                chk("frame_len", mon_cnt, c_FRAME);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got word %0h expected none", mon_acc);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("frame_word", int'(mon_acc), int'(exp_w));
`ifdef SLAVE_TX_PARITY_EN
                    chk("frame_parity", int'(tx_data), int'(^exp_w));
`endif
                end
                mon_cnt = 0;
                last_done_cyc = cyc;
                frames_seen++;
            end else if (mon_cnt >= c_FRAME) begin
                chk("frame_overrun", mon_cnt, c_FRAME - 1);
                mon_cnt = 0;
            end
        end else begin
            if (mon_cnt != 0) begin
                chk("frame_truncated", mon_cnt, 0);
                mon_cnt = 0;
            end
            chk("idle_tx_data", int'(tx_data), 0);
            chk("idle_done", int'(slave_tx_done), 0);
        end
    end

    task automatic wait_drain(input int bound);
        int n = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || tx_valid) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", sb_q.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        tick();
        datain = v.din;
        slave_valid = 1'b1;
        master_ready = 1'b1;
        @(negedge clk);
        chk("vec_ready", int'(slave_ready), 1);
        sb_q.push_back(v.din);
        tick();
        slave_valid = 1'b0;
        @(negedge clk);
        chk("vec_no_fallthrough", int'(tx_valid), 0);
        chk("vec_level", int'(fifo_level), 1);
        for (int i = 0; i < c_FRAME; i++) begin
            @(negedge clk);
            chk("vec_valid", int'(tx_valid), 1);
            chk("vec_bit", int'(tx_data), (i < 8) ? int'(v.seq[7-i]) : int'(v.par));
            chk("vec_done", int'(slave_tx_done), (i == c_FRAME - 1) ? 1 : 0);
        end
        @(negedge clk);
        chk("vec_idle_after", int'(tx_valid), 0);
    endtask

    task automatic run_msb(input vec_t v);
        tick();
        m_datain = v.din;
        m_valid = 1'b1;
        m_mready = 1'b1;
        tick();
        m_valid = 1'b0;
        @(negedge clk);
        chk("msb_no_fallthrough", int'(m_tx_valid), 0);
        for (int i = 0; i < c_FRAME; i++) begin
            @(negedge clk);
            chk("msb_valid", int'(m_tx_valid), 1);
            chk("msb_bit", int'(m_tx_data), (i < 8) ? int'(v.seq[7-i]) : int'(v.par));
            chk("msb_done", int'(m_done), (i == c_FRAME - 1) ? 1 : 0);
        end
        @(negedge clk);
        chk("msb_idle_after", int'(m_tx_valid), 0);
        chk("msb_idle_data", int'(m_tx_data), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t lsb_tab[6];
        vec_t msb_tab[2];
        int   n;
        int   f0;
        int   seen_valid;

        lsb_tab[0] = '{din: 8'hA5, seq: 8'b10100101, par: 1'b0};
        lsb_tab[1] = '{din: 8'h01, seq: 8'b10000000, par: 1'b1};
        lsb_tab[2] = '{din: 8'hC8, seq: 8'b00010011, par: 1'b1};
        lsb_tab[3] = '{din: 8'h00, seq: 8'b00000000, par: 1'b0};
        lsb_tab[4] = '{din: 8'hFF, seq: 8'b11111111, par: 1'b0};
        lsb_tab[5] = '{din: 8'h6B, seq: 8'b11010110, par: 1'b1};
        msb_tab[0] = '{din: 8'h81, seq: 8'b10000001, par: 1'b0};
        msb_tab[1] = '{din: 8'h34, seq: 8'b00110100, par: 1'b1};

        reset = 1'b1;
        datain = '0;
        slave_valid = 1'b0;
        master_ready = 1'b0;
        m_datain = '0;
        m_valid = 1'b0;
        m_mready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_done", int'(slave_tx_done), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ready", int'(slave_ready), 1);
        chk("rst_msb_valid", int'(m_tx_valid), 0);
        chk("rst_msb_ready", int'(m_ready), 1);

        for (int k = 0; k < 6; k++) run_vec(lsb_tab[k]);
        for (int k = 0; k < 2; k++) run_msb(msb_tab[k]);
        wait_drain(50);

        // Backpressure: master held off, fifth word refused.
        tick();
        master_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            datain = 8'hB0 + 8'(i);
            slave_valid = 1'b1;
            @(negedge clk);
            chk("bp_ready", int'(slave_ready), (i < 4) ? 1 : 0);
            if (slave_ready) sb_q.push_back(datain);
            tick();
        end
        slave_valid = 1'b0;
        @(negedge clk);
        chk("bp_level_full", int'(fifo_level), 4);
        chk("bp_ready_low", int'(slave_ready), 0);
        chk("bp_no_tx", int'(tx_valid), 0);
        tick();
        master_ready = 1'b1;
        wait_drain(200);
        chk("bp_level_empty", int'(fifo_level), 0);

        // master_ready dropped mid-frame: frame completes, next waits in IDLE.
        tick();
        master_ready = 1'b1;
        datain = 8'h3C;
        slave_valid = 1'b1;
        @(negedge clk);
        sb_q.push_back(datain);
        tick();
        datain = 8'h5A;
        @(negedge clk);
        sb_q.push_back(datain);
        tick();
        slave_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < c_FRAME; i++) begin
            if (i > 0) @(negedge clk);
            chk("mr_valid", int'(tx_valid), 1);
            chk("mr_done", int'(slave_tx_done), (i == c_FRAME - 1) ? 1 : 0);
            if (i == 3) master_ready = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mr_hold_idle", int'(tx_valid), 0);
        end
        chk("mr_hold_level", int'(fifo_level), 1);
        master_ready = 1'b1;
        datain = 8'h77;
        slave_valid = 1'b1;
        sb_q.push_back(datain);
        tick();
        slave_valid = 1'b0;
        @(negedge clk);
        chk("mr_resume_valid", int'(tx_valid), 1);
        chk("mr_push_pop_level", int'(fifo_level), 1);
        wait_drain(100);

        // Reset mid-frame with two words queued.
        tick();
        master_ready = 1'b1;
        datain = 8'hFF;
        slave_valid = 1'b1;
        @(negedge clk);
        sb_q.push_back(datain);
        tick();
        datain = 8'h11;
        @(negedge clk);
        sb_q.push_back(datain);
        tick();
        datain = 8'h22;
        @(negedge clk);
        sb_q.push_back(datain);
        tick();
        slave_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("rm_pre_valid", int'(tx_valid), 1);
        chk("rm_pre_level", int'(fifo_level), 2);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rm_tx_valid", int'(tx_valid), 0);
        chk("rm_tx_data", int'(tx_data), 0);
        chk("rm_done", int'(slave_tx_done), 0);
        chk("rm_level", int'(fifo_level), 0);
        chk("rm_ready", int'(slave_ready), 1);
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tx_valid || slave_tx_done) seen_valid++;
        end
        chk("rm_no_leftover", seen_valid, 0);

        // Continuous stream of ten words through the depth-4 FIFO.
        gap_q.delete();
        f0 = frames_seen;
        master_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            datain = 8'(i * 37 + 5);
            slave_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!slave_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("stream_ready", int'(slave_ready), 1);
            sb_q.push_back(datain);
        end
        tick();
        slave_valid = 1'b0;
        wait_drain(300);
        chk("stream_frames", frames_seen - f0, 10);
        chk("stream_gap_count", gap_q.size(), 10);
        for (int k = 1; k < gap_q.size(); k++) begin
            chk("stream_gap", gap_q[k], 1);
        end
        chk("stream_level", int'(fifo_level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slave_tx_serializer.md
SLAVE_TX_SERIALIZER -- requirements
Module: slave_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bits per word (range 2..32).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the words buffered (power of two, at least 2).
REQ-003 Parameter MSB_FIRST, default 0, SHALL select serial bit order: 0 = LSB first, 1 = MSB first.
REQ-004 Port clk, input, 1, SHALL be the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-006 Port datain, input, DATA_WIDTH, SHALL carry the slave read word.
REQ-007 Port slave_valid, input, 1, SHALL mark datain valid.
REQ-008 Port slave_ready, output, 1, SHALL indicate the FIFO can accept a word.
REQ-009 Port master_ready, input, 1, SHALL indicate the master can receive a frame.
REQ-010 Port tx_data, output, 1, SHALL be the registered serial data bit.
REQ-011 Port tx_valid, output, 1, SHALL be high exactly on cycles where tx_data carries a frame bit.
REQ-012 Port slave_tx_done, output, 1, SHALL pulse on the last bit of each frame.
REQ-013 Port fifo_level, output, clog2(FIFO_DEPTH+1), SHALL report the number of words stored.

Function
REQ-014 The FIFO push SHALL occur when slave_valid and slave_ready are both high.
REQ-015 slave_ready SHALL equal (fifo_level < FIFO_DEPTH), from registered state only.
REQ-016 The FSM SHALL have states IDLE, DATA and PARITY; PARITY is reachable only with the parity macro.
REQ-017 In IDLE, if fifo_level > 0 and master_ready = 1, the FSM SHALL pop the head word into a shift register, clear the bit counter and enter DATA.
REQ-018 In DATA, each cycle SHALL drive one bit with tx_valid = 1, in the order set by MSB_FIRST; after DATA_WIDTH bits, the FSM goes to PARITY if enabled, else IDLE.
REQ-019 The first bit SHALL appear on the cycle after the pop; a frame SHALL occupy DATA_WIDTH cycles (DATA_WIDTH+1 with parity), followed by at least one IDLE cycle.
REQ-020 slave_tx_done SHALL be high for one cycle, coincident with the final frame bit.
REQ-021 master_ready SHALL be sampled only in IDLE; deassertion mid-frame SHALL NOT stall or abort the frame.
REQ-022 There SHALL be no fall-through: a push into an empty FIFO is poppable no earlier than the next cycle.
REQ-023 On simultaneous push and pop, fifo_level SHALL be unchanged; when full, the push is refused because slave_ready = 0.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Outside a frame, tx_data SHALL be 0 and tx_valid SHALL be 0.

Reset
REQ-026 Reset SHALL force IDLE, flush the FIFO and zero the pointers and count.
REQ-027 On the cycle after reset: tx_data = 0, tx_valid = 0, slave_tx_done = 0, fifo_level = 0, slave_ready = 1.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with no done pulse and the remaining bits discarded.

Configuration
REQ-029 When macro SLAVE_TX_PARITY_EN is defined, the block SHALL append one even-parity bit (XOR of the word) after the data bits, with tx_valid = 1; slave_tx_done then pulses on the parity bit.
REQ-030 Without SLAVE_TX_PARITY_EN, PARITY logic SHALL be absent and frames SHALL be DATA_WIDTH bits long.

Structure
REQ-031 Package slave_tx_pkg SHALL hold the FSM state encoding (IDLE = 0, DATA = 1, PARITY = 2) and the state-width constant.
REQ-032 The FIFO SHALL be the sub-module slave_tx_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/level ports), and the FSM and shifter SHALL remain in the top level.

Verification
REQ-033 Push 0xA5 with master_ready = 1 and LSB-first -> tx_data sequence 1,0,1,0,0,1,0,1 over 8 cycles, done on the 8th.
REQ-034 MSB_FIRST = 1, push 0x81 -> sequence 1,0,0,0,0,0,0,1; with SLAVE_TX_PARITY_EN -> a 9th bit of 0 and done on the 9th bit.
REQ-035 master_ready = 0, push 5 words at FIFO_DEPTH = 4 -> slave_ready drops after the 4th push, the 5th is refused and fifo_level = 4.
REQ-036 Drop master_ready during bit 3 of 0x3C -> the frame completes, and the next frame waits for master_ready = 1 in IDLE.
REQ-037 Assert reset at bit 5 of 0xFF with 2 words queued -> the next cycle shows tx_valid = 0, fifo_level = 0, slave_ready = 1 and no done pulse.
REQ-038 Stream 10 words continuously -> words arrive in order, each frame is separated by exactly one IDLE cycle, and the pointers wrap correctly.
